// File: rtl/pll_lock_supervisor.sv
// Lock qualifier for the clock-decrease PLL: pulses the PLL reset, waits for a
// stable synchronised lock, retries on timeout and re-arms on loss of lock.
module pll_lock_supervisor #(
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CNT_W          = 8
) (
   input  logic             i_refclk,
   input  logic             i_rst_n,
   input  logic             i_pll_locked,
   input  logic             i_restart,
   output logic             o_pll_rst,
   output logic             o_pll_ready,
   output logic             o_timeout_flag,
   output logic [CNT_W-1:0] o_retry_cnt,
   output logic [CNT_W-1:0] o_lock_loss_cnt,
   output logic [1:0]       o_state
);

   localparam int RST_W = $clog2(RST_CYCLES);
   localparam int STB_W = $clog2(STABLE_CYCLES);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RESET_PLL = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_STABLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_sync1;
   logic             r_sync2;
   logic [RST_W-1:0] r_rst_cnt;
   logic [STB_W-1:0] r_stab_cnt;
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_pll_rst;
   logic             r_pll_ready;
   logic             r_timeout_flag;
   logic [CNT_W-1:0] r_retry_cnt;
   logic [CNT_W-1:0] r_lock_loss_cnt;

   logic             w_locked_s;
   logic             w_timeout;
   logic             w_lock_lost;
   logic             w_pll_rst_d;
   logic             w_pll_ready_d;
   logic             w_qualifying;
   logic             w_next_qualifying;

   assign w_locked_s = r_sync2;

   // i_restart is a single-cycle request sampled on every edge; it overrides
   // every other transition and suppresses counter updates in that cycle.
   always_ff @(posedge i_refclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= S_RESET_PLL;
         r_sync1         <= 1'b0;
         r_sync2         <= 1'b0;
         r_rst_cnt       <= '0;
         r_stab_cnt      <= '0;
         r_tmo_cnt       <= '0;
         r_pll_rst       <= 1'b1;
         r_pll_ready     <= 1'b0;
         r_timeout_flag  <= 1'b0;
         r_retry_cnt     <= '0;
         r_lock_loss_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_sync1     <= i_pll_locked;
         r_sync2     <= r_sync1;
         r_pll_rst   <= w_pll_rst_d;
         r_pll_ready <= w_pll_ready_d;

         if (r_state == S_RESET_PLL && w_next_state == S_RESET_PLL && !i_restart)
            r_rst_cnt <= r_rst_cnt + 1'b1;
         else
            r_rst_cnt <= '0;

         if (r_state == S_STABLE && w_next_state == S_STABLE)
            r_stab_cnt <= r_stab_cnt + 1'b1;
         else
            r_stab_cnt <= '0;

         // The timeout window spans WAIT_LOCK and STABLE, so glitches back to
         // WAIT_LOCK do not restart it.
         if (w_qualifying && w_next_qualifying)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         else
            r_tmo_cnt <= '0;

         if (w_timeout) begin
            r_timeout_flag <= 1'b1;
            if (r_retry_cnt != '1)
               r_retry_cnt <= r_retry_cnt + 1'b1;
         end

         if (w_lock_lost && r_lock_loss_cnt != '1)
            r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
      end
   end

   assign w_qualifying      = (r_state == S_WAIT_LOCK) || (r_state == S_STABLE);
   assign w_next_qualifying = (w_next_state == S_WAIT_LOCK) || (w_next_state == S_STABLE);

   // Timeout is checked first in both qualifying states so the window can
   // never run past its last count.
   always_comb begin
      w_next_state = r_state;
      w_timeout    = 1'b0;
      w_lock_lost  = 1'b0;
      if (i_restart) begin
         w_next_state = S_RESET_PLL;
      end else begin
         case (r_state)
            S_RESET_PLL: begin
               if (r_rst_cnt == RST_LAST)
                  w_next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (r_tmo_cnt == TMO_LAST) begin
                  w_next_state = S_RESET_PLL;
                  w_timeout    = 1'b1;
               end else if (w_locked_s) begin
                  w_next_state = S_STABLE;
               end
            end
            S_STABLE: begin
               if (r_tmo_cnt == TMO_LAST) begin
                  w_next_state = S_RESET_PLL;
                  w_timeout    = 1'b1;
               end else if (!w_locked_s) begin
                  w_next_state = S_WAIT_LOCK;
               end else if (r_stab_cnt == STB_LAST) begin
                  w_next_state = S_RUN;
               end
            end
            S_RUN: begin
               if (!w_locked_s) begin
                  w_next_state = S_RESET_PLL;
                  w_lock_lost  = 1'b1;
               end
            end
            default: w_next_state = S_RESET_PLL;
         endcase
      end
   end

   // Both outputs decode the same next state, so ready and PLL reset can
   // never be high together.
   always_comb begin
      w_pll_rst_d   = 1'b0;
      w_pll_ready_d = 1'b0;
      if (w_next_state == S_RESET_PLL)
         w_pll_rst_d = 1'b1;
      if (w_next_state == S_RUN)
         w_pll_ready_d = 1'b1;
   end

   assign o_pll_rst       = r_pll_rst;
   assign o_pll_ready     = r_pll_ready;
   assign o_timeout_flag  = r_timeout_flag;
   assign o_retry_cnt     = r_retry_cnt;
   assign o_lock_loss_cnt = r_lock_loss_cnt;
   assign o_state         = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scenarios for pll_lock_supervisor with small parameters; expected
// output vectors are queued as stimulus is driven and compared each cycle.
module tb_pll_lock_supervisor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst;
   logic       pll_ready;
   logic       timeout_flag;
   logic [3:0] retry_cnt;
   logic [3:0] lock_loss_cnt;
   logic [1:0] state;

   logic [10:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .RST_CYCLES     (4),
      .STABLE_CYCLES  (8),
      .TIMEOUT_CYCLES (32),
      .CNT_W          (4)
   ) dut (
      .i_refclk        (clk),
      .i_rst_n         (rst_n),
      .i_pll_locked    (pll_locked),
      .i_restart       (restart),
      .o_pll_rst       (pll_rst),
      .o_pll_ready     (pll_ready),
      .o_timeout_flag  (timeout_flag),
      .o_retry_cnt     (retry_cnt),
      .o_lock_loss_cnt (lock_loss_cnt),
      .o_state         (state)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Vector layout: {pll_rst, pll_ready, timeout_flag, retry_cnt, lock_loss_cnt}
   function automatic logic [10:0] mk(input logic rst, input logic rdy, input logic tf,
                                      input int retry, input int loss);
      return {rst, rdy, tf, retry[3:0], loss[3:0]};
   endfunction

   task automatic pop_compare(input string tag);
      logic [10:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, {21'd0, pll_rst, pll_ready, timeout_flag, retry_cnt, lock_loss_cnt},
                   {21'd0, e});
      end
   endtask

   task automatic expect_for(input int n, input string tag, input logic [10:0] e);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(e);
         @(negedge clk);
         pop_compare(tag);
      end
   endtask

   task automatic expect_now(input string tag, input logic [10:0] e);
      exp_q.push_back(e);
      pop_compare(tag);
   endtask

   initial begin
      rst_n      = 1'b0;
      pll_locked = 1'b1;
      restart    = 1'b0;
      repeat (3) @(negedge clk);
      expect_now("rst_vals", mk(1, 0, 0, 0, 0));
      check_val("rst_state", {30'd0, state}, 32'd0);
      rst_n = 1'b1;

      // Clean lock from release
      expect_for(3, "s1_pll_rst", mk(1, 0, 0, 0, 0));
      expect_for(9, "s1_qualify", mk(0, 0, 0, 0, 0));
      expect_for(5, "s1_run",     mk(0, 1, 0, 0, 0));

      // One-cycle lock drop in RUN
      pll_locked = 1'b0;
      expect_for(1, "s3_drop",     mk(0, 1, 0, 0, 0));
      pll_locked = 1'b1;
      expect_for(1, "s3_sync_lag", mk(0, 1, 0, 0, 0));
      expect_for(4, "s3_rst",      mk(1, 0, 0, 0, 1));
      expect_for(9, "s3_relock",   mk(0, 0, 0, 0, 1));
      expect_for(3, "s3_run",      mk(0, 1, 0, 0, 1));

      // Restart in RUN, then again in RESET_PLL at rst_cnt=2
      restart = 1'b1;
      expect_for(1, "s5_restart_run", mk(1, 0, 0, 0, 1));
      restart = 1'b0;
      expect_for(2, "s5_rst_a",       mk(1, 0, 0, 0, 1));
      restart = 1'b1;
      expect_for(1, "s5_restart_rst", mk(1, 0, 0, 0, 1));
      restart = 1'b0;
      expect_for(3, "s5_rst_b",       mk(1, 0, 0, 0, 1));
      expect_for(9, "s5_relock",      mk(0, 0, 0, 0, 1));
      expect_for(3, "s5_run",         mk(0, 1, 0, 0, 1));

      // Lock glitch seen while STABLE at stab_cnt=5
      restart = 1'b1;
      expect_for(1, "s4_restart",    mk(1, 0, 0, 0, 1));
      restart = 1'b0;
      expect_for(3, "s4_rst",        mk(1, 0, 0, 0, 1));
      expect_for(5, "s4_pre_glitch", mk(0, 0, 0, 0, 1));
      pll_locked = 1'b0;
      expect_for(1, "s4_glitch",     mk(0, 0, 0, 0, 1));
      pll_locked = 1'b1;
      expect_for(10, "s4_requalify", mk(0, 0, 0, 0, 1));
      expect_for(2, "s4_run",        mk(0, 1, 0, 0, 1));

      // No lock at all: periodic retries, retry_cnt saturates at 15
      restart    = 1'b1;
      pll_locked = 1'b0;
      expect_for(1, "s2_restart", mk(1, 0, 0, 0, 1));
      restart = 1'b0;
      expect_for(3, "s2_rst0",    mk(1, 0, 0, 0, 1));
      for (int k = 1; k <= 17; k++) begin
         expect_for(32, "s2_wait",    mk(0, 0, (k > 1), ((k - 1) > 15) ? 15 : (k - 1), 1));
         expect_for(4,  "s2_repulse", mk(1, 0, 1, (k > 15) ? 15 : k, 1));
      end

      // Back to RUN with nonzero counters, then asynchronous reset
      restart    = 1'b1;
      pll_locked = 1'b1;
      expect_for(1, "s6_restart", mk(1, 0, 1, 15, 1));
      restart = 1'b0;
      expect_for(3, "s6_rst",     mk(1, 0, 1, 15, 1));
      expect_for(9, "s6_qualify", mk(0, 0, 1, 15, 1));
      expect_for(2, "s6_run",     mk(0, 1, 1, 15, 1));
      #2;
      rst_n = 1'b0;
      #1;
      expect_now("s6_async_rst", mk(1, 0, 0, 0, 0));
      check_val("s6_async_state", {30'd0, state}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
